// File: rtl/pipe_buf_stage_if.sv
// rtl/pipe_buf_stage_if.sv - handshake bundle between a pipeline buffer stage and its neighbours
//
// Signals:
//   in_valid / in_data / in_ready    upstream payload handshake
//   out_valid / out_data / out_ready downstream payload handshake
//   flush                            synchronous squash of held and incoming payloads
//   cnt_clr / stall_cnt              stall counter clear and value
// Modports:
//   master  the side that drives the stage (upstream/downstream/control)
//   slave   the buffer stage itself
interface pipe_buf_stage_if #(
    parameter int DATA_W = 41,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              flush;
    logic              cnt_clr;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, in_data, out_ready, flush, cnt_clr,
        input  in_ready, out_valid, out_data, stall_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush, cnt_clr,
        output in_ready, out_valid, out_data, stall_cnt
    );
endinterface

// File: rtl/pipe_buf_stage.sv
// rtl/pipe_buf_stage.sv - generic pipeline buffer register with optional skid, flush and stall counter
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      pipe_buf_stage_if.slave: in_valid/in_data/in_ready (upstream),
//            out_valid/out_data/out_ready (downstream), flush, cnt_clr, stall_cnt
// Parameters:
//   DATA_W  payload width
//   SKID    1 = two-entry skid buffer with registered in_ready, 0 = single register
//   BUBBLE  payload shown while the stage holds nothing valid
//   CNT_W   stall counter width
module pipe_buf_stage #(
    parameter int                DATA_W = 41,
    parameter int                SKID   = 1,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(41'h0_0000_0013),
    parameter int                CNT_W  = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    pipe_buf_stage_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CNT_W-1:0]  stall_cnt;

    logic in_ready;
    logic accept;
    logic xfer;

    // With the skid, in_ready depends only on a register, so the upstream
    // ready path never sees downstream out_ready combinationally.
    assign in_ready = (SKID != 0) ? ~skid_valid : (~main_valid | bus.out_ready);
    assign accept   = bus.in_valid & in_ready;
    assign xfer     = main_valid & bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid <= 1'b0;
            main_data  <= BUBBLE;
            skid_valid <= 1'b0;
            skid_data  <= BUBBLE;
        end else if (bus.flush) begin
            // A transfer in this cycle already completed downstream; anything
            // accepted this cycle is dropped along with the held payloads.
            main_valid <= 1'b0;
            main_data  <= BUBBLE;
            skid_valid <= 1'b0;
            skid_data  <= BUBBLE;
        end else if (SKID != 0) begin
            if (!main_valid) begin
                if (accept) begin
                    main_data  <= bus.in_data;
                    main_valid <= 1'b1;
                end
            end else if (!skid_valid) begin
                if (accept && xfer) begin
                    main_data <= bus.in_data;
                end else if (accept) begin
                    skid_data  <= bus.in_data;
                    skid_valid <= 1'b1;
                end else if (xfer) begin
                    main_valid <= 1'b0;
                    main_data  <= BUBBLE;
                end
            end else if (xfer) begin
                // Full: the older payload leaves, the skid entry moves up.
                main_data  <= skid_data;
                skid_data  <= BUBBLE;
                skid_valid <= 1'b0;
            end
        end else begin
            if (accept) begin
                main_data  <= bus.in_data;
                main_valid <= 1'b1;
            end else if (xfer) begin
                main_valid <= 1'b0;
                main_data  <= BUBBLE;
            end
        end
    end

    // Stall counter ignores flush; clear beats increment; sticks at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (bus.cnt_clr) begin
            stall_cnt <= '0;
        end else if (main_valid && !bus.out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.stall_cnt = stall_cnt;

endmodule
